// File: rtl/piso_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// piso_if : word-in / bit-out bundle between upstream logic and the piso block
// Rev 1.0
// -----------------------------------------------------------------------------
interface piso_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  en_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic                  data_o;
  logic                  data_valid_o;
  logic                  last_o;
  logic                  busy_o;

  modport master (
    output en_i, data_i, valid_i,
    input  ready_o, data_o, data_valid_o, last_o, busy_o
  );

  modport slave (
    input  en_i, data_i, valid_i,
    output ready_o, data_o, data_valid_o, last_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/piso.sv
`default_nettype none
// -----------------------------------------------------------------------------
// piso : parallel-in serial-out transmitter with a one-word holding buffer
// Rev 1.0
// -----------------------------------------------------------------------------
module piso #(
  parameter int    DATA_WIDTH = 8,
  parameter string DIRECTION  = "msb_first"
) (
  input  logic  clk_i,
  input  logic  s_rst_i,
  piso_if.slave bus
);
  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] sr_shifted;
  logic                  sr_out;
  logic                  accept;

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("piso: DATA_WIDTH must be >= 2");
  end

  if (DIRECTION == "msb_first") begin : g_msb
    assign sr_shifted = {sr_q[DATA_WIDTH-2:0], 1'b0};
    assign sr_out     = sr_q[DATA_WIDTH-1];
  end else if (DIRECTION == "lsb_first") begin : g_lsb
    assign sr_shifted = {1'b0, sr_q[DATA_WIDTH-1:1]};
    assign sr_out     = sr_q[0];
  end else begin : g_bad_dir
    $error("piso: DIRECTION must be \"msb_first\" or \"lsb_first\"");
    assign sr_shifted = sr_q;
    assign sr_out     = 1'b0;
  end

  assign accept = bus.valid_i && bus.ready_o;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          sr_d        = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = SHIFT;
        end else if (accept) begin
          sr_d    = bus.data_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          hold_d      = bus.data_i;
          hold_full_d = 1'b1;
        end
        if (bus.en_i) begin
          if (cnt_q != CNT_LAST) begin
            sr_d  = sr_shifted;
            cnt_d = cnt_q + 1'b1;
          end else if (hold_full_q) begin
            sr_d        = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else begin
            // A word accepted on this same edge sits in HOLD and costs one idle cycle.
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign bus.ready_o      = !hold_full_q && !s_rst_i;
  assign bus.data_o       = (state_q == SHIFT) ? sr_out : 1'b0;
  assign bus.data_valid_o = (state_q == SHIFT);
  assign bus.last_o       = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign bus.busy_o       = (state_q == SHIFT) || hold_full_q;
endmodule
`default_nettype wire

// File: tb/tb_piso.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_piso : directed self-checking bench for piso (msb_first and lsb_first)
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_piso;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  piso_if #(.DATA_WIDTH(8)) bm ();
  piso_if #(.DATA_WIDTH(8)) bl ();

  piso #(.DATA_WIDTH(8), .DIRECTION("msb_first")) dut_m (
    .clk_i   (clk),
    .s_rst_i (rst),
    .bus     (bm)
  );

  piso #(.DATA_WIDTH(8), .DIRECTION("lsb_first")) dut_l (
    .clk_i   (clk),
    .s_rst_i (rst),
    .bus     (bl)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bm.ready_o !== 1'b0 || bl.ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_low: got m=%b l=%b want 0", bm.ready_o, bl.ready_o);
    end
    n_checks++;
    if ({bm.data_o, bm.data_valid_o, bm.last_o, bm.busy_o,
         bl.data_o, bl.data_valid_o, bl.last_o, bl.busy_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got m=%b%b%b%b l=%b%b%b%b want 0",
               bm.data_o, bm.data_valid_o, bm.last_o, bm.busy_o,
               bl.data_o, bl.data_valid_o, bl.last_o, bl.busy_o);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bm.ready_o !== 1'b1 || bl.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got m=%b l=%b want 1", bm.ready_o, bl.ready_o);
    end
  endtask

  task automatic test_msb_single();
    logic [7:0] exp_bits = 8'b11000001;
    logic [2:0] got, want;
    @(negedge clk);
    bm.en_i = 1'b1; bm.data_i = 8'hC1; bm.valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bm.valid_i = 1'b0;
      got  = {bm.data_o, bm.data_valid_o, bm.last_o};
      want = {exp_bits[7-i], 1'b1, (i == 7)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL msb_single bit%0d: got d/v/l=%b want %b", i, got, want);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({bm.data_valid_o, bm.busy_o, bm.last_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL msb_single_after: got v/b/l=%b%b%b want 000",
               bm.data_valid_o, bm.busy_o, bm.last_o);
    end
  endtask

  task automatic test_lsb_single();
    logic [7:0] exp_bits = 8'b10000011;
    logic [2:0] got, want;
    @(negedge clk);
    bl.en_i = 1'b1; bl.data_i = 8'hC1; bl.valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bl.valid_i = 1'b0;
      got  = {bl.data_o, bl.data_valid_o, bl.last_o};
      want = {exp_bits[7-i], 1'b1, (i == 7)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL lsb_single bit%0d: got d/v/l=%b want %b", i, got, want);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({bl.data_valid_o, bl.busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL lsb_single_after: got v/b=%b%b want 00", bl.data_valid_o, bl.busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] stream = 24'b11000001_01011010_10100101;
    logic [3:0]  got, want;
    @(negedge clk);
    bm.en_i = 1'b1; bm.data_i = 8'hC1; bm.valid_i = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      got  = {bm.data_o, bm.data_valid_o, bm.last_o, bm.ready_o};
      want = {stream[24-i], 1'b1, (i % 8 == 0), (i == 1 || i == 9 || i >= 17)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back bit%0d: got d/v/l/r=%b want %b", i, got, want);
      end
      if (i == 1) bm.data_i = 8'h5A;
      if (i == 2) bm.data_i = 8'hA5;
      if (i == 10) bm.valid_i = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({bm.data_valid_o, bm.busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL back_to_back_after: got v/b=%b%b want 00", bm.data_valid_o, bm.busy_o);
    end
  endtask

  task automatic test_slow_enable();
    logic [3:0] got, want;
    @(negedge clk);
    bm.en_i = 1'b0; bm.data_i = 8'h80; bm.valid_i = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      bm.valid_i = 1'b0;
      got  = {bm.data_o, bm.data_valid_o, bm.last_o, bm.busy_o};
      want = {(k <= 4), 1'b1, (k >= 29), 1'b1};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL slow_enable cyc%0d: got d/v/l/b=%b want %b", k, got, want);
      end
      bm.en_i = (k % 4 == 0);
    end
    @(negedge clk);
    bm.en_i = 1'b1;
    n_checks++;
    if ({bm.data_valid_o, bm.busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL slow_enable_after: got v/b=%b%b want 00", bm.data_valid_o, bm.busy_o);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] exp_bits = 8'b00001111;
    logic [2:0] got, want;
    @(negedge clk);
    bm.en_i = 1'b1; bm.data_i = 8'hFF; bm.valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bm.valid_i = 1'b0;
      n_checks++;
      if ({bm.data_o, bm.data_valid_o} !== 2'b11) begin
        n_fail++;
        $display("FAIL midword_pre bit%0d: got d/v=%b%b want 11", i, bm.data_o, bm.data_valid_o);
      end
    end
    rst = 1'b1; bm.data_i = 8'h55; bm.valid_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bm.data_o, bm.data_valid_o, bm.last_o, bm.busy_o, bm.ready_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL midword_reset: got d/v/l/b/r=%b%b%b%b%b want 00000",
               bm.data_o, bm.data_valid_o, bm.last_o, bm.busy_o, bm.ready_o);
    end
    rst = 1'b0; bm.valid_i = 1'b0;
    #1;
    n_checks++;
    if (bm.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midword_ready: got %b want 1", bm.ready_o);
    end
    @(negedge clk);
    n_checks++;
    if ({bm.data_valid_o, bm.busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL midword_not_captured: got v/b=%b%b want 00", bm.data_valid_o, bm.busy_o);
    end
    bm.data_i = 8'h0F; bm.valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bm.valid_i = 1'b0;
      got  = {bm.data_o, bm.data_valid_o, bm.last_o};
      want = {exp_bits[7-i], 1'b1, (i == 7)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL midword_resend bit%0d: got d/v/l=%b want %b", i, got, want);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_bubble();
    logic [7:0] first_bits  = 8'b11000001;
    logic [7:0] second_bits = 8'b00111100;
    logic [2:0] got, want;
    @(negedge clk);
    bm.en_i = 1'b1; bm.data_i = 8'hC1; bm.valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bm.valid_i = 1'b0;
      got  = {bm.data_o, bm.data_valid_o, bm.last_o};
      want = {first_bits[7-i], 1'b1, (i == 7)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL bubble_first bit%0d: got d/v/l=%b want %b", i, got, want);
      end
    end
    n_checks++;
    if (bm.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble_ready_on_last: got %b want 1", bm.ready_o);
    end
    bm.data_i = 8'h3C; bm.valid_i = 1'b1;
    @(negedge clk);
    bm.valid_i = 1'b0;
    n_checks++;
    if ({bm.data_o, bm.data_valid_o, bm.busy_o, bm.ready_o} !== 4'b0010) begin
      n_fail++;
      $display("FAIL bubble_gap: got d/v/b/r=%b%b%b%b want 0010",
               bm.data_o, bm.data_valid_o, bm.busy_o, bm.ready_o);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got  = {bm.data_o, bm.data_valid_o, bm.last_o};
      want = {second_bits[7-i], 1'b1, (i == 7)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL bubble_second bit%0d: got d/v/l=%b want %b", i, got, want);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({bm.data_valid_o, bm.busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL bubble_after: got v/b=%b%b want 00", bm.data_valid_o, bm.busy_o);
    end
  endtask

  initial begin
    bm.en_i = 1'b0; bm.data_i = '0; bm.valid_i = 1'b0;
    bl.en_i = 1'b0; bl.data_i = '0; bl.valid_i = 1'b0;
    test_reset();
    test_msb_single();
    test_lsb_single();
    test_back_to_back();
    test_slow_enable();
    test_reset_midword();
    test_bubble();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/piso.md
# piso

Parallel-in serial-out transmitter with a valid/ready word interface and a one-word holding buffer. It accepts DATA_WIDTH-bit words from upstream logic and shifts them out one bit per enable strobe, MSB-first or LSB-first. It is the transmit-side counterpart of the `sipo` deserializer. Back-to-back words stream with no gap between them.

## Interface
- DATA_WIDTH, 8, word width; must be >= 2, elaboration error otherwise
- DIRECTION, "msb_first", bit order; "msb_first" or "lsb_first", any other value is an elaboration error
- clk_i  input  1  clock; all logic on rising edge
- s_rst_i  input  1  reset, synchronous, active-high
- en_i  input  1  shift strobe; one bit is consumed per clk_i edge with en_i=1 while shifting
- data_i  input  DATA_WIDTH  parallel word
- valid_i  input  1  data_i valid
- ready_o  output  1  block can accept a word; transfer occurs on an edge with valid_i && ready_o
- data_o  output  1  serial bit
- data_valid_o  output  1  data_o carries a word bit
- last_o  output  1  data_o is the final bit of the current word
- busy_o  output  1  a word is shifting or held

## Operation
- Storage:
  - shift register SR (DATA_WIDTH)
  - bit counter CNT (0..DATA_WIDTH-1, width clog2(DATA_WIDTH))
  - holding register HOLD plus flag HOLD_FULL
  - FSM with states IDLE and SHIFT
- ready_o = !HOLD_FULL && !s_rst_i (combinational).
- Accept in IDLE with HOLD_FULL=0: data_i loads SR directly; CNT <= 0; state <= SHIFT.
- Accept in SHIFT: data_i loads HOLD; HOLD_FULL <= 1.
- IDLE with HOLD_FULL=1 (only reachable via the corner case below): SR <= HOLD; HOLD_FULL <= 0; CNT <= 0; state <= SHIFT.
- SHIFT, edge with en_i=1 and CNT < DATA_WIDTH-1:
  - msb_first: SR shifts left (zero fill)
  - lsb_first: SR shifts right (zero fill)
  - CNT increments
- SHIFT, edge with en_i=1 and CNT = DATA_WIDTH-1 (word done):
  - HOLD_FULL=1: SR <= HOLD, HOLD_FULL <= 0, CNT <= 0, stay in SHIFT.
  - HOLD_FULL=0: state <= IDLE, CNT <= 0.
  - If an accept happens on the same edge with HOLD_FULL=0, the word goes to HOLD. The next cycle is IDLE with HOLD_FULL=1, which costs exactly one bubble cycle.
- en_i=0 in SHIFT: SR, CNT and state hold. en_i is ignored in IDLE.
- Outputs:
  - data_o = SR[DATA_WIDTH-1] (msb_first) or SR[0] (lsb_first) in SHIFT; 0 in IDLE
  - data_valid_o = (state == SHIFT)
  - last_o = (state == SHIFT) && (CNT == DATA_WIDTH-1)
  - busy_o = (state == SHIFT) || HOLD_FULL
- Upstream keeps data_i stable while valid_i=1 and ready_o=0. valid_i is not required to stay asserted.

## Timing
- Reset (s_rst_i=1 at an edge):
  - state = IDLE; SR, HOLD and CNT = 0; HOLD_FULL = 0
  - data_o, data_valid_o, last_o and busy_o = 0 from the following cycle
  - ready_o = 0 during every cycle s_rst_i=1, and 1 on the first cycle after
  - Reset overrides everything, including a mid-word shift and a same-edge accept; a partially sent word is discarded.
- Load latency: accept at edge N, then the first bit is on data_o with data_valid_o=1 in cycle N+1.
- Each bit holds until an edge with en_i=1. With en_i tied to 1, a word occupies exactly DATA_WIDTH cycles.
- Back-to-back: if HOLD is filled before the word-done edge, the next word's first bit appears in the cycle right after the previous last_o bit. data_valid_o stays high with no gap.
- ready_o deasserts the cycle after an accept in SHIFT. It reasserts the cycle after HOLD transfers to SR.
- Max throughput is one word per DATA_WIDTH enabled edges.

## Test plan
- DATA_WIDTH=8, msb_first, en_i=1, accept 0xC1 from IDLE -> data_o 1,1,0,0,0,0,0,1 over 8 cycles; data_valid_o high for those 8 cycles; last_o high only on the 8th; busy_o 0 after.
- DATA_WIDTH=8, lsb_first, en_i=1, accept 0xC1 -> data_o 1,0,0,0,0,0,1,1.
- msb_first, en_i=1, 0xC1 then 0x5A offered on the cycle after -> 16 contiguous valid bits 11000001 01011010; last_o on bits 8 and 16; ready_o low from the 0x5A accept until the 0x5A reload; a third word offered meanwhile is not accepted until then.
- en_i high one cycle in four, word 0x80 msb_first -> each bit held 4 cycles; total 32 cycles of data_valid_o; CNT frozen while en_i=0.
- Word 0xFF, en_i=1, s_rst_i pulsed after 3 bits with 0x55 offered the same cycle -> next cycle all outputs 0, ready_o 1, 0x55 not captured; a new 0x0F sent afterwards shifts out complete from bit 0.
- 0xC1 shifting with HOLD empty, 0x3C accepted exactly on the last_o edge -> data_valid_o 0 for exactly one cycle, then 0x3C shifts out as 0,0,1,1,1,1,0,0.
